// File: rtl/ow_slave_pkg.sv
// Shared types and constants for the 1-Wire slave: FSM states, ROM opcodes,
// microsecond timing constants and the cycle-conversion helper.
package ow_slave_pkg;
  localparam int TW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_PRES_WAIT, S_PRES, S_ROM_CMD, S_READ_ROM,
    S_MATCH_ROM, S_SEARCH, S_FUNC, S_WAIT_RST
  } state_t;

  localparam logic [7:0] OP_READ_ROM   = 8'h33;
  localparam logic [7:0] OP_MATCH_ROM  = 8'h55;
  localparam logic [7:0] OP_SKIP_ROM   = 8'hCC;
  localparam logic [7:0] OP_SEARCH_ROM = 8'hF0;
  localparam logic [7:0] OP_OD_SKIP    = 8'h3C;
  localparam logic [7:0] OP_OD_MATCH   = 8'h69;

  localparam int STD_PRES_WAIT_US = 20;
  localparam int STD_PRES_US      = 120;
  localparam int OD_RST_US        = 48;
  localparam int OD_PRES_WAIT_US  = 2;
  localparam int OD_PRES_US       = 10;
  localparam int OD_SAMPLE_US     = 3;
  localparam int OD_HOLD_US       = 3;

  // Clamped to [1, 2**TW-1] so a timer compare can never be unreachable.
  function automatic logic [TW-1:0] us2cyc(input int clks, input int us);
    int p;
    p = clks * us;
    if (p > (2**TW) - 1) p = (2**TW) - 1;
    if (p < 1) p = 1;
    return p[TW-1:0];
  endfunction
endpackage

// File: rtl/ow_slot_engine.sv
// Line front end: 2-flop synchroniser, falling-edge detect, reset-length and
// slot timers, write-slot sampling and read-slot pull-down. Overdrive timings
// exist only with OW_SLAVE_OVERDRIVE_EN.
module ow_slot_engine import ow_slave_pkg::*; #(
  parameter int CLKS_PER_US = 8,
  parameter int RST_MIN_US  = 480,
  parameter int SAMPLE_US   = 30,
  parameter int HOLD_US     = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic i_io,
  input  logic i_od,
  input  logic i_slot_is_read,
  input  logic i_tx_bit,
  output logic o_pd,
  output logic o_start,
  output logic o_bit_valid,
  output logic o_bit_in,
  output logic o_rst_arm,
  output logic o_rst_long,
  output logic o_rst_seen
);
  localparam logic [TW-1:0] T_RST_STD = us2cyc(CLKS_PER_US, RST_MIN_US);
  localparam logic [TW-1:0] T_SMP_STD = us2cyc(CLKS_PER_US, SAMPLE_US);
  localparam logic [TW-1:0] T_HLD_STD = us2cyc(CLKS_PER_US, HOLD_US);
`ifdef OW_SLAVE_OVERDRIVE_EN
  localparam logic [TW-1:0] T_RST_OD = us2cyc(CLKS_PER_US, OD_RST_US);
  localparam logic [TW-1:0] T_SMP_OD = us2cyc(CLKS_PER_US, OD_SAMPLE_US);
  localparam logic [TW-1:0] T_HLD_OD = us2cyc(CLKS_PER_US, OD_HOLD_US);
`else
  localparam logic [TW-1:0] T_RST_OD = T_RST_STD;
  localparam logic [TW-1:0] T_SMP_OD = T_SMP_STD;
  localparam logic [TW-1:0] T_HLD_OD = T_HLD_STD;
`endif

  logic [1:0]    r_sync;
  logic          r_line_d, r_busy, r_rd, r_pd, r_bv, r_bit, r_seen;
  logic [TW-1:0] r_low, r_tim;
  logic          w_line, w_fall, w_rise, w_end;
  logic [TW-1:0] w_t_rst, w_t_smp, w_t_hld;

  assign w_t_rst = i_od ? T_RST_OD : T_RST_STD;
  assign w_t_smp = i_od ? T_SMP_OD : T_SMP_STD;
  assign w_t_hld = i_od ? T_HLD_OD : T_HLD_STD;

  assign w_line     = r_sync[1];
  assign w_fall     = r_line_d & ~w_line;
  assign w_rise     = ~r_line_d & w_line;
  assign o_rst_arm  = (r_low >= w_t_rst);
  assign o_rst_long = (r_low >= T_RST_STD);
  assign w_end      = (r_tim >= (r_rd ? w_t_hld : w_t_smp));
  // Edges during a running slot or a reset-length low are not new slots.
  assign o_start    = w_fall & ~r_busy & ~o_rst_arm;

  assign o_pd        = r_pd;
  assign o_bit_valid = r_bv;
  assign o_bit_in    = r_bit;
  assign o_rst_seen  = r_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_line_d <= 1'b1;
      r_low    <= '0;
      r_tim    <= '0;
      r_busy   <= 1'b0;
      r_rd     <= 1'b0;
      r_pd     <= 1'b0;
      r_bv     <= 1'b0;
      r_bit    <= 1'b0;
      r_seen   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_io};
      r_line_d <= w_line;
      r_low    <= w_line ? '0 : ((r_low == '1) ? r_low : r_low + 1'b1);
      r_seen   <= w_rise & o_rst_arm;
      r_bv     <= 1'b0;
      if (o_rst_arm) begin
        r_busy <= 1'b0;
        r_pd   <= 1'b0;
      end else if (r_busy) begin
        if (w_end) begin
          r_busy <= 1'b0;
          r_pd   <= 1'b0;
          r_bv   <= 1'b1;
          r_bit  <= w_line;
        end else begin
          r_tim <= r_tim + 1'b1;
        end
      end else if (o_start) begin
        r_busy <= 1'b1;
        r_tim  <= {{(TW-1){1'b0}}, 1'b1};
        r_rd   <= i_slot_is_read;
        r_pd   <= i_slot_is_read & ~i_tx_bit;
      end
    end
  end
endmodule

// File: rtl/ow_slave_core.sv
// 1-Wire slave: presence, ROM function layer and byte-wide function port.
// OW_SLAVE_OVERDRIVE_EN adds Overdrive Skip/Match and overdrive timing.
module ow_slave_core import ow_slave_pkg::*; #(
  parameter int CLKS_PER_US = 8,
  parameter int RST_MIN_US  = 480,
  parameter int SAMPLE_US   = 30,
  parameter int HOLD_US     = 30
) (
  input  logic        CLK_IOX,
  input  logic        IOX_RST,
  input  logic        IO_BUF,
  output logic        IO_PD,
  input  logic [63:0] P_ROMID,
  output logic [7:0]  FN_RXDATA,
  output logic        FN_RXVALID,
  input  logic        FN_TXREQ,
  input  logic [7:0]  FN_TXDATA,
  output logic        FN_TXACK,
  output logic        SELECTED,
  output logic        RESET_DET,
  output logic        OD_MODE
);
  localparam logic [TW-1:0] T_PW_STD = us2cyc(CLKS_PER_US, STD_PRES_WAIT_US);
  localparam logic [TW-1:0] T_PR_STD = us2cyc(CLKS_PER_US, STD_PRES_US);
`ifdef OW_SLAVE_OVERDRIVE_EN
  localparam logic [TW-1:0] T_PW_OD = us2cyc(CLKS_PER_US, OD_PRES_WAIT_US);
  localparam logic [TW-1:0] T_PR_OD = us2cyc(CLKS_PER_US, OD_PRES_US);
`endif

  state_t        r_state, w_next;
  logic [5:0]    r_idx;
  logic [1:0]    r_sub;
  logic [2:0]    r_fcnt;
  logic [TW-1:0] r_tim;
  logic [7:0]    r_cmd, r_rx, r_tx, r_rxd;
  logic          r_tx_act, r_pres_pd, r_sel, r_rxv, r_ack;
  logic          w_od, w_slot_pd, w_start, w_bv, w_bit_in;
  logic          w_rst_arm, w_rst_long, w_rst_seen;
  logic          w_rd, w_txb, w_rom_bit, w_last, w_tdone;
  logic [7:0]    w_byte, w_rxb;
  logic [TW-1:0] w_tlim;

  ow_slot_engine #(
    .CLKS_PER_US(CLKS_PER_US), .RST_MIN_US(RST_MIN_US),
    .SAMPLE_US(SAMPLE_US), .HOLD_US(HOLD_US)
  ) u_slot (
    .clk(CLK_IOX), .rst(IOX_RST), .i_io(IO_BUF), .i_od(w_od),
    .i_slot_is_read(w_rd), .i_tx_bit(w_txb), .o_pd(w_slot_pd),
    .o_start(w_start), .o_bit_valid(w_bv), .o_bit_in(w_bit_in),
    .o_rst_arm(w_rst_arm), .o_rst_long(w_rst_long), .o_rst_seen(w_rst_seen)
  );

  assign w_rom_bit = P_ROMID[r_idx];
  assign w_last    = (r_idx == 6'd63);
  assign w_byte    = {w_bit_in, r_cmd[7:1]};
  assign w_rxb     = {w_bit_in, r_rx[7:1]};
  assign w_tdone   = (r_tim >= w_tlim);

`ifdef OW_SLAVE_OVERDRIVE_EN
  logic r_od;
  assign w_tlim = (r_state == S_PRES_WAIT) ? (r_od ? T_PW_OD : T_PW_STD)
                                           : (r_od ? T_PR_OD : T_PR_STD);
  // A standard-length low ends overdrive even before the line rises.
  always_ff @(posedge CLK_IOX) begin
    if (IOX_RST) r_od <= 1'b0;
    else if (w_rst_long) r_od <= 1'b0;
    else if (r_state == S_ROM_CMD && w_bv && r_idx == 6'd7 &&
             (w_byte == OP_OD_SKIP || w_byte == OP_OD_MATCH)) r_od <= 1'b1;
  end
  assign w_od = r_od;
`else
  assign w_tlim = (r_state == S_PRES_WAIT) ? T_PW_STD : T_PR_STD;
  assign w_od   = 1'b0;
`endif

  always_ff @(posedge CLK_IOX) begin
    if (IOX_RST) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_rst_seen) w_next = S_PRES_WAIT;
    else begin
      case (r_state)
        S_PRES_WAIT: if (w_tdone) w_next = S_PRES;
        S_PRES:      if (w_tdone) w_next = S_ROM_CMD;
        S_ROM_CMD:
          if (w_bv && r_idx == 6'd7) begin
            case (w_byte)
              OP_READ_ROM:   w_next = S_READ_ROM;
              OP_MATCH_ROM:  w_next = S_MATCH_ROM;
              OP_SKIP_ROM:   w_next = S_FUNC;
              OP_SEARCH_ROM: w_next = S_SEARCH;
`ifdef OW_SLAVE_OVERDRIVE_EN
              OP_OD_SKIP:    w_next = S_FUNC;
              OP_OD_MATCH:   w_next = S_MATCH_ROM;
`endif
              default:       w_next = S_WAIT_RST;
            endcase
          end
        S_READ_ROM: if (w_bv && w_last) w_next = S_FUNC;
        S_MATCH_ROM, S_SEARCH:
          if (w_bv && (r_state == S_MATCH_ROM || r_sub == 2'd2)) begin
            if (w_bit_in != w_rom_bit) w_next = S_WAIT_RST;
            else if (w_last)           w_next = S_FUNC;
          end
        default: ;
      endcase
    end
  end

  // Slot type and bit to drive; the engine latches these at the falling edge.
  always_comb begin
    w_rd  = 1'b0;
    w_txb = 1'b1;
    case (r_state)
      S_READ_ROM: begin w_rd = 1'b1; w_txb = w_rom_bit; end
      S_SEARCH:
        if (r_sub != 2'd2) begin w_rd = 1'b1; w_txb = w_rom_bit ^ r_sub[0]; end
      S_FUNC:
        if (r_fcnt == 3'd0 && !r_tx_act) begin w_rd = FN_TXREQ; w_txb = FN_TXDATA[0]; end
        else begin w_rd = r_tx_act; w_txb = r_tx[0]; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_IOX) begin
    if (IOX_RST) begin
      r_idx <= '0; r_sub <= '0; r_fcnt <= '0; r_tim <= '0;
      r_cmd <= '0; r_rx <= '0; r_tx <= '0; r_rxd <= '0;
      r_tx_act <= 1'b0; r_pres_pd <= 1'b0; r_sel <= 1'b0;
      r_rxv <= 1'b0; r_ack <= 1'b0;
    end else begin
      r_rxv     <= 1'b0;
      r_ack     <= 1'b0;
      r_sel     <= (w_next == S_FUNC);
      r_pres_pd <= (w_next == S_PRES) & ~(w_rst_arm | w_rst_long);
      if (w_next != r_state) begin
        r_tim <= {{(TW-1){1'b0}}, 1'b1};
        r_idx <= '0; r_sub <= '0; r_fcnt <= '0; r_tx_act <= 1'b0;
      end else begin
        if (r_tim != '1) r_tim <= r_tim + 1'b1;
        if (w_start && r_state == S_FUNC && r_fcnt == 3'd0 && !r_tx_act) begin
          r_tx_act <= FN_TXREQ;
          r_tx     <= FN_TXDATA;
        end
        if (w_bv) begin
          case (r_state)
            S_ROM_CMD: begin r_cmd <= w_byte; r_idx <= r_idx + 6'd1; end
            S_READ_ROM, S_MATCH_ROM: r_idx <= r_idx + 6'd1;
            S_SEARCH:
              if (r_sub == 2'd2) begin r_sub <= '0; r_idx <= r_idx + 6'd1; end
              else r_sub <= r_sub + 2'd1;
            S_FUNC: begin
              r_fcnt <= r_fcnt + 3'd1;
              if (r_tx_act) begin
                r_tx <= {1'b0, r_tx[7:1]};
                if (r_fcnt == 3'd7) begin r_ack <= 1'b1; r_tx_act <= 1'b0; end
              end else begin
                r_rx <= w_rxb;
                if (r_fcnt == 3'd7) begin r_rxd <= w_rxb; r_rxv <= 1'b1; end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign IO_PD      = w_slot_pd | r_pres_pd;
  assign FN_RXDATA  = r_rxd;
  assign FN_RXVALID = r_rxv;
  assign FN_TXACK   = r_ack;
  assign SELECTED   = r_sel;
  assign RESET_DET  = w_rst_seen;
  assign OD_MODE    = w_od;
endmodule
